// File: rtl/afc_sar_controller.sv
// Successive-approximation search on the 9-bit VCO capacitor code.
// Each trial settles, counts divided-VCO edges over a window, then keeps or drops one bit.
module afc_sar_controller #(
  parameter int SETTLE_CYC = 16,
  parameter int WIN_CYC    = 512,
  parameter int TARGET     = 100,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             vco_div,
  output logic [8:0]       cap_code,
  output logic             afc_busy,
  output logic             afc_done,
  output logic [CNT_W-1:0] meas_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_DECIDE, S_DONE} state_t;

  localparam int TMR_W = $clog2((SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TGT         = CNT_W'(TARGET);

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [8:0]       cap_code_q, cap_code_d;
  logic [3:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             edge_pulse;
  logic [CNT_W-1:0] cnt_next;
  logic [8:0]       bit_m;

  always_comb begin
    sync_d     = {sync_q[1:0], vco_div};
    edge_pulse = sync_q[1] & ~sync_q[2];
    // Saturating increment; the edge on the final window cycle is still included.
    cnt_next   = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(edge_pulse);
    bit_m      = 9'd1 << idx_q;

    state_d    = state_q;
    tmr_d      = tmr_q;
    edge_cnt_d = edge_cnt_q;
    meas_cnt_d = meas_cnt_q;
    cap_code_d = cap_code_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cap_code_d = 9'h100;
          idx_d      = 4'd8;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          tmr_d      = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d      = '0;
          edge_cnt_d = '0;
          state_d    = S_MEASURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_MEASURE: begin
        edge_cnt_d = cnt_next;
        if (tmr_q == WIN_LAST) begin
          tmr_d      = '0;
          meas_cnt_d = cnt_next;
          state_d    = S_DECIDE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DECIDE: begin
        // A low count means the VCO is too slow: drop this capacitor bit.
        if (meas_cnt_q < TGT) cap_code_d = cap_code_q & ~bit_m;
        if (idx_q != 4'd0) begin
          cap_code_d = cap_code_d | (bit_m >> 1);
          idx_d      = idx_q - 4'd1;
          state_d    = S_SETTLE;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      meas_cnt_q <= '0;
      cap_code_q <= 9'h000;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      tmr_q      <= tmr_d;
      edge_cnt_q <= edge_cnt_d;
      meas_cnt_q <= meas_cnt_d;
      cap_code_q <= cap_code_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cap_code = cap_code_q;
  assign afc_busy = busy_q;
  assign afc_done = done_q;
  assign meas_cnt = meas_cnt_q;

endmodule

// File: tb/tb_afc_sar_controller.sv
// Directed bench for afc_sar_controller with a queue of expected search results.
module tb_afc_sar_controller;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       vco_div;
  logic [8:0] cap_code;
  logic       afc_busy;
  logic       afc_done;
  logic [9:0] meas_cnt;

  int total = 0;
  int bad = 0;

  // vco_half == 0 selects the hand-driven waveform; -1 selects the code-dependent VCO model.
  int   vco_half = 0;
  int   vco_ph = 0;
  logic vco_auto = 1'b0;
  logic vco_man = 1'b0;
  assign vco_div = (vco_half == 0) ? vco_man : vco_auto;

  logic [8:0] exp_code_q[$];
  logic [9:0] exp_cnt_q[$];
  logic [8:0] trial_exp[$];
  logic [8:0] obs_code_q[$];
  int         obs_cyc_q[$];

  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic       prev_busy = 1'b0;
  logic [8:0] prev_code = 9'h000;

  afc_sar_controller dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .vco_div  (vco_div),
    .cap_code (cap_code),
    .afc_busy (afc_busy),
    .afc_done (afc_done),
    .meas_cnt (meas_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int half;
    half = (vco_half < 0) ? ((cap_code <= 9'h0A5) ? 2 : 4) : vco_half;
    if (half > 0) begin
      if (vco_ph >= half - 1) begin
        vco_auto = ~vco_auto;
        vco_ph   = 0;
      end else begin
        vco_ph = vco_ph + 1;
      end
    end
  end

  // Records every new trial code presented while the search is busy.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mon_en && afc_busy === 1'b1 && (prev_busy !== 1'b1 || cap_code !== prev_code)) begin
      obs_code_q.push_back(cap_code);
      obs_cyc_q.push_back(cyc);
    end
    prev_busy = afc_busy;
    prev_code = cap_code;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Returns on the negedge right after the start-sample edge.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_search(input string tag, input logic [8:0] ec, input logic [9:0] en,
                            input bit pokes, input bit hold);
    int n;
    exp_code_q.push_back(ec);
    exp_cnt_q.push_back(en);
    start_pulse();
    chk({tag, "_busy_rise"}, afc_busy, 1);
    chk({tag, "_first_trial"}, cap_code, 9'h100);
    n = 0;
    while (afc_busy === 1'b1 && n < 6000) begin
      if (pokes) start = (n == 600 || n == 4332);
      if (hold && n >= 4000) start = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, n, 4761);
    chk({tag, "_done"}, afc_done, 1);
    chk({tag, "_code"}, cap_code, exp_code_q.pop_front());
    chk({tag, "_meas"}, meas_cnt, exp_cnt_q.pop_front());
  endtask

  task automatic window_case(input string tag, input int kb, input logic [8:0] ec,
                             input logic [9:0] en);
    exp_code_q.push_back(ec);
    exp_cnt_q.push_back(en);
    vco_half = 0;
    vco_man  = 1'b0;
    start_pulse();
    for (int k = 0; k < 530; k++) begin
      vco_man = (k == 5 || k == 6) ||
                (k >= 20 && k <= 413 && ((k - 20) % 4) < 2) ||
                (k == kb || k == kb + 1);
      @(negedge clk);
    end
    chk({tag, "_meas"}, meas_cnt, exp_cnt_q.pop_front());
    chk({tag, "_code"}, cap_code, exp_code_q.pop_front());
    do_reset();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_code", cap_code, 9'h000);
    chk("rst_busy", afc_busy, 0);
    chk("rst_done", afc_done, 0);
    chk("rst_meas", meas_cnt, 0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", afc_busy, 0);
    chk("idle_code", cap_code, 9'h000);

    vco_half = 2;
    run_search("fast", 9'h1FF, 10'd128, 1'b0, 1'b0);

    vco_half = 4;
    run_search("slow", 9'h000, 10'd64, 1'b0, 1'b0);

    vco_half = -1;
    trial_exp = '{9'h100, 9'h080, 9'h0C0, 9'h0A0, 9'h0B0, 9'h0A8, 9'h0A4, 9'h0A6, 9'h0A5};
    obs_code_q.delete();
    obs_cyc_q.delete();
    mon_en = 1'b1;
    run_search("model", 9'h0A5, 10'd128, 1'b0, 1'b0);
    mon_en = 1'b0;
    chk("model_ntrials", obs_code_q.size(), 9);
    for (int i = 0; i < 9 && obs_code_q.size() > 0; i++) begin
      chk($sformatf("model_trial%0d", i), obs_code_q.pop_front(), trial_exp[i]);
      if (i > 0) chk($sformatf("model_gap%0d", i), obs_cyc_q[i] - obs_cyc_q[i-1], 529);
    end

    vco_half = 2;
    run_search("poke", 9'h1FF, 10'd128, 1'b1, 1'b1);
    @(negedge clk);
    chk("hold_done_clr", afc_done, 0);
    chk("hold_busy", afc_busy, 1);
    chk("hold_code", cap_code, 9'h100);
    start = 1'b0;

    repeat (3 * 529 + 100) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_code", cap_code, 9'h000);
    chk("abort_busy", afc_busy, 0);
    chk("abort_done", afc_done, 0);
    chk("abort_meas", meas_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_abort_busy", afc_busy, 0);
    chk("post_abort_code", cap_code, 9'h000);

    window_case("win_last", 525, 9'h180, 10'd100);
    window_case("win_after", 526, 9'h080, 10'd99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afc_sar_controller.md
Name: afc_sar_controller

Overview:
- Automatic-frequency-calibration (AFC) engine for the ETROC2 PLL VCO.
- Runs a 9-bit successive-approximation search on the VCO capacitor-bank code. For each trial code it compares a divided-VCO edge count against a target over a fixed reference-clock window.
- Drives the 9-bit code plus a busy flag into the downstream code hold/protect stage. That stage passes the code while busy is high and latches it when busy falls.

Parameters:
- SETTLE_CYC, 16, clk cycles the VCO settles after each code change before measuring.
- WIN_CYC, 512, clk cycles in the measurement window.
- TARGET, 100, edge count at the desired frequency; an equal count counts as "too fast".
- CNT_W, 10, width of the edge counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  reference clock (40 MHz).
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  level-sampled start request. Acted on only in IDLE or DONE.
- vco_div  input  1  divided VCO clock, asynchronous to clk. Each high phase and each low phase must last at least 2 clk periods.
- cap_code  output  9  VCO capacitor code; a larger code gives a lower frequency.
- afc_busy  output  1  high for the whole search.
- afc_done  output  1  high from search end until the next start.
- meas_cnt  output  CNT_W  edge count of the most recent completed window.

Behaviour:
- Reset (asynchronous, rstn low):
  - cap_code=9'h000, afc_busy=0, afc_done=0, meas_cnt=0.
  - State=IDLE; synchronizer and counters cleared.
  - Reset mid-search aborts immediately to these values.
- vco_div path:
  - 2-flop synchronizer, then a third flop for rising-edge detect, giving a 1-cycle edge pulse.
  - Pulses are counted only while in MEASURE. Edge-pulse latency is 2-3 clk.
- State machine IDLE -> SETTLE -> MEASURE -> DECIDE -> (SETTLE | DONE):
  - IDLE/DONE, start sampled 1 at a clk edge. At that edge: cap_code=9'h100, bit index=8, afc_busy=1, afc_done=0, go to SETTLE.
  - SETTLE: exactly SETTLE_CYC cycles, then MEASURE. The edge counter is cleared on entry to MEASURE.
  - MEASURE: exactly WIN_CYC cycles counting edge pulses, with saturating add. Then go to DECIDE; meas_cnt is loaded with the final count on the same edge.
  - DECIDE (1 cycle), evaluated on meas_cnt:
    - If meas_cnt < TARGET, clear cap_code[idx] (too slow, so less capacitance).
    - If meas_cnt >= TARGET, keep cap_code[idx] set.
    - If idx>0: set cap_code[idx-1], decrement idx, go to SETTLE.
    - If idx==0: go to DONE with afc_busy=0 and afc_done=1 on that same edge.
  - DONE: holds cap_code and afc_done. start behaves as it does in IDLE.
- start while busy: ignored, no restart. start held high continuously: a new search begins on the cycle after DONE is entered.
- Timing:
  - Each bit takes SETTLE_CYC+WIN_CYC+1 cycles. With defaults, afc_busy is high for exactly 9×529 = 4761 cycles.
  - cap_code changes only on SETTLE entry or in DECIDE, never during MEASURE.
  - cap_code is stable on the edge where afc_busy falls.
- Saturation: a count reaching 2^CNT_W-1 stays there until the next MEASURE entry.
- An edge pulse arriving outside MEASURE is discarded.

Test Plan:
1. rstn low mid-search, e.g. during bit 5 MEASURE -> all outputs return to reset values asynchronously. After release, outputs stay idle until start.
2. vco_div constant period 4 clk (128 edges/window), start pulse:
   - afc_busy rises on the start-sample edge and stays high exactly 4761 cycles.
   - Result: cap_code=9'h1FF, afc_done=1, meas_cnt=128.
3. vco_div constant period 8 clk (64 edges/window) -> cap_code=9'h000, meas_cnt=64.
4. Behavioural VCO model:
   - Period is 4 clk when cap_code<=9'h0A5, otherwise 8 clk.
   - Check the trial sequence 100,080,0C0,0A0,0B0,0A8,0A4,0A6,0A5.
   - Final cap_code=9'h0A5; cap_code is constant during every MEASURE.
5. start pulses during search at bits 7 and 0 -> no effect, total busy length unchanged. start held high -> second search begins 1 cycle after afc_done rises, and afc_done clears.
6. Window boundary:
   - Edge placed at the last MEASURE cycle vs. the first DECIDE cycle: only pulses during MEASURE are counted.
   - With TARGET=count exactly, the bit is kept. With TARGET=count+1, the bit is cleared.
